booth_r4_iter_mul: RTL and testbench

Iterative radix-4 modified-Booth multiplier sequencer. It retires one Booth digit of the multiplier per cycle and adds ±0/±1/±2 × multiplicand into a 2*WIDTH accumulator. Operands can be signed or unsigned, selected per operand. It sits in the ALU as the area-optimised multiply unit, with a valid/ready handshake on input and output.

---
 rtl/booth_r4_iter_mul_if.sv | 34 +++
 rtl/booth_r4_iter_mul.sv | 120 ++++++++++++
 tb/tb_booth_r4_iter_mul.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/booth_r4_iter_mul_if.sv
// Operand/result handshake bundle for booth_r4_iter_mul.
//   in_valid_i/in_ready_o   : operand request handshake
//   a_i, b_i                : multiplicand, multiplier (b is Booth-encoded)
//   a_signed_i, b_signed_i  : per-operand two's complement select
//   flush_i                 : abort the operation in flight
//   out_valid_o/out_ready_i : product handshake
//   prod_o                  : 2*WIDTH product
//   busy_o                  : operation in flight
// The slave modport is the multiplier side; master is the requester/consumer.
interface booth_r4_iter_mul_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic                 a_signed_i;
    logic                 b_signed_i;
    logic                 flush_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [2*WIDTH-1:0]   prod_o;
    logic                 busy_o;

    modport slave (
        input  in_valid_i, a_i, b_i, a_signed_i, b_signed_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, prod_o, busy_o
    );

    modport master (
        output in_valid_i, a_i, b_i, a_signed_i, b_signed_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, prod_o, busy_o
    );
endinterface

// File: rtl/booth_r4_iter_mul.sv
// Iterative radix-4 modified-Booth multiplier.
// Retires one Booth digit of the multiplier per cycle, adding 0/+-1/+-2 x A x 4^k
// into a 2*WIDTH accumulator. DIG_NUM = WIDTH/2+1 cycles per operation.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   bus    : booth_r4_iter_mul_if.slave (operand/result handshake, flush, busy)
module booth_r4_iter_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    booth_r4_iter_mul_if.slave   bus
);
    localparam int DIG_NUM = WIDTH / 2 + 1;
    localparam int PW      = 2 * WIDTH;
    // Extended multiplier (WIDTH+2) plus the implicit b[-1] in bit 0.
    localparam int BW      = WIDTH + 3;
    localparam int CW      = $clog2(DIG_NUM + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [PW-1:0] r_a;      // multiplicand pre-scaled by 4^k
    logic [BW-1:0] r_b;      // multiplier, bits [2:0] hold the current digit window
    logic [PW-1:0] r_acc;
    logic [PW-1:0] r_prod;
    logic [CW-1:0] r_k;

    logic          w_accept;
    logic          w_last;
    logic          w_neg;
    logic [PW-1:0] w_op;
    logic [PW-1:0] w_sum;
    logic [PW-1:0] w_a_ext;
    logic [BW-1:0] w_b_ext;

    // Flush in IDLE blocks a same-cycle accept.
    assign w_accept = (r_state == S_IDLE) && bus.in_valid_i && !bus.flush_i;
    assign w_last   = (r_k == CW'(DIG_NUM - 1));

    assign w_a_ext = {{WIDTH{bus.a_signed_i & bus.a_i[WIDTH-1]}}, bus.a_i};
    assign w_b_ext = {{2{bus.b_signed_i & bus.b_i[WIDTH-1]}}, bus.b_i, 1'b0};

    // Booth digit decode from {b[2k+1], b[2k], b[2k-1]}.
    always_comb begin
        w_op  = '0;
        w_neg = 1'b0;
        case (r_b[2:0])
            3'b001, 3'b010: w_op = r_a;
            3'b011:         w_op = r_a << 1;
            3'b100: begin
                w_op  = r_a << 1;
                w_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                w_op  = r_a;
                w_neg = 1'b1;
            end
            default: begin
                w_op  = '0;
                w_neg = 1'b0;
            end
        endcase
    end

    // Subtraction folded into the single adder: ~op with carry-in 1.
    assign w_sum = r_acc + (w_neg ? ~w_op : w_op) + {{(PW-1){1'b0}}, w_neg};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_prod  <= '0;
            r_k     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_a_ext;
                        r_b     <= w_b_ext;
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (bus.flush_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_sum;
                        r_a   <= r_a << 2;
                        r_b   <= r_b >> 2;
                        if (w_last) begin
                            r_prod  <= w_sum;
                            r_state <= S_DONE;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // A handshake coinciding with flush is simply treated as flushed.
                    if (bus.flush_i || bus.out_ready_i)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = (r_state == S_IDLE);
    assign bus.out_valid_o = (r_state == S_DONE);
    assign bus.prod_o      = r_prod;
    assign bus.busy_o      = (r_state != S_IDLE);
endmodule

// File: tb/tb_booth_r4_iter_mul.sv
module tb_booth_r4_iter_mul;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_r4_iter_mul_if #(.WIDTH(8))  bus8();
    booth_r4_iter_mul_if #(.WIDTH(16)) bus16();

    booth_r4_iter_mul #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(bus8));
    booth_r4_iter_mul #(.WIDTH(16)) dut16 (.clk_i(clk), .rst_i(rst), .bus(bus16));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: interpret operands as integers, multiply, keep 2w bits.
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input bit as, input bit bs, input int w);
        longint ax, bx, p;
        logic [63:0] pm;
        ax = longint'(a);
        bx = longint'(b);
        if (as && a[w-1]) ax = ax - (longint'(1) << w);
        if (bs && b[w-1]) bx = bx - (longint'(1) << w);
        p  = ax * bx;
        pm = p;
        pm = pm & ((64'd1 << (2 * w)) - 64'd1);
        return pm[31:0];
    endfunction

    task automatic drive(input bit w16, input bit v, input logic [15:0] a, input logic [15:0] b,
                         input bit as, input bit bs);
        if (w16) begin
            bus16.in_valid_i = v; bus16.a_i = a; bus16.b_i = b;
            bus16.a_signed_i = as; bus16.b_signed_i = bs;
        end else begin
            bus8.in_valid_i = v; bus8.a_i = a[7:0]; bus8.b_i = b[7:0];
            bus8.a_signed_i = as; bus8.b_signed_i = bs;
        end
    endtask

    task automatic start_op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                            input bit as, input bit bs);
        int n = 0;
        while (!(w16 ? bus16.in_ready_o : bus8.in_ready_o) && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("ready_timeout", 0, 1);
        drive(w16, 1'b1, a, b, as, bs);
        tick();
        drive(w16, 1'b0, a, b, as, bs);
    endtask

    task automatic wait_valid(input bit w16, output int lat, output logic [31:0] prod);
        lat = 0;
        while (!(w16 ? bus16.out_valid_o : bus8.out_valid_o) && lat < 40) begin
            tick();
            lat++;
        end
        if (!(w16 ? bus16.out_valid_o : bus8.out_valid_o)) chk("valid_timeout", 0, 1);
        prod = w16 ? {16'h0, bus16.prod_o} : {24'h0, bus8.prod_o};
    endtask

    task automatic run_op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                          input bit as, input bit bs, output int lat, output logic [31:0] prod);
        start_op(w16, a, b, as, bs);
        wait_valid(w16, lat, prod);
        tick();
    endtask

    task automatic dir8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input bit as, input bit bs, input logic [15:0] exp);
        int lat;
        logic [31:0] p;
        run_op(1'b0, {8'h0, a}, {8'h0, b}, as, bs, lat, p);
        chk(tag, p, {16'h0, exp});
        chk({tag, "_lat"}, lat, 5);
    endtask

    task automatic chk_reset8(input string tag);
        chk({tag, "_busy"},  bus8.busy_o, 0);
        chk({tag, "_ready"}, bus8.in_ready_o, 1);
        chk({tag, "_ovld"},  bus8.out_valid_o, 0);
        chk({tag, "_prod"},  bus8.prod_o, 0);
    endtask

    initial begin
        int lat;
        logic [31:0] p, held;
        bit seen;

        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        bus8.flush_i = 0;  bus8.out_ready_i = 1;
        bus16.flush_i = 0; bus16.out_ready_i = 1;
        rst = 1;
        tick(); tick();
        chk_reset8("rst8");
        chk("rst16_ready", bus16.in_ready_o, 1);
        chk("rst16_ovld",  bus16.out_valid_o, 0);
        chk("rst16_prod",  bus16.prod_o, 0);
        rst = 0;
        tick();

        // Basic op: latency and return to IDLE
        run_op(1'b0, 16'd3, 16'd5, 1'b0, 1'b0, lat, p);
        chk("t1_prod", p, 32'h000F);
        chk("t1_lat", lat, 5);
        chk("t1_idle_ready", bus8.in_ready_o, 1);
        chk("t1_idle_busy",  bus8.busy_o, 0);

        // Corner operands and mixed signedness
        dir8("uu_ff_ff", 8'hFF, 8'hFF, 0, 0, 16'hFE01);
        dir8("ss_80_80", 8'h80, 8'h80, 1, 1, 16'h4000);
        dir8("ss_7f_80", 8'h7F, 8'h80, 1, 1, 16'hC080);
        dir8("su_ff_ff", 8'hFF, 8'hFF, 1, 0, 16'hFF01);
        dir8("us_ff_ff", 8'hFF, 8'hFF, 0, 1, 16'hFF01);
        dir8("uu_zero",  8'h00, 8'hA5, 0, 0, 16'h0000);

        // Backpressure: result held, new requests ignored
        bus8.out_ready_i = 0;
        start_op(1'b0, 16'h0012, 16'h0034, 1'b0, 1'b0);
        wait_valid(1'b0, lat, p);
        held = p;
        chk("bp_prod", held, {16'h0, 16'h0012 * 16'h0034});
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 16'h00AA, 16'h0055, 1'b1, 1'b0);
            tick();
            chk("bp_ovld", bus8.out_valid_o, 1);
            chk("bp_hold", {24'h0, bus8.prod_o}, held);
            chk("bp_ready", bus8.in_ready_o, 0);
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        bus8.out_ready_i = 1;
        tick();
        chk("bp_release_ovld", bus8.out_valid_o, 0);
        chk("bp_release_ready", bus8.in_ready_o, 1);
        tick();
        chk("bp_no_accept", bus8.busy_o, 0);

        // Flush in CALC: result dropped
        start_op(1'b0, 16'h0005, 16'h0007, 1'b0, 1'b0);
        tick();
        bus8.flush_i = 1;
        tick();
        bus8.flush_i = 0;
        chk("fl_busy", bus8.busy_o, 0);
        chk("fl_ready", bus8.in_ready_o, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus8.out_valid_o) seen = 1;
            tick();
        end
        chk("fl_no_valid", seen, 0);
        dir8("fl_after", 8'h02, 8'hFE, 1, 1, 16'hFFFC);

        // Flush in IDLE blocks a same-cycle accept
        bus8.flush_i = 1;
        drive(1'b0, 1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        bus8.flush_i = 0;
        chk("fl_idle_busy", bus8.busy_o, 0);

        // Flush in DONE with same-cycle handshake
        start_op(1'b0, 16'h0009, 16'h0009, 1'b0, 1'b0);
        wait_valid(1'b0, lat, p);
        bus8.flush_i = 1;
        tick();
        bus8.flush_i = 0;
        chk("fl_done_ovld", bus8.out_valid_o, 0);
        chk("fl_done_ready", bus8.in_ready_o, 1);

        // Reset mid-CALC and in DONE
        start_op(1'b0, 16'h0033, 16'h0044, 1'b0, 1'b0);
        tick();
        rst = 1; tick(); rst = 0;
        chk_reset8("rst_calc");
        start_op(1'b0, 16'h0033, 16'h0044, 1'b0, 1'b0);
        wait_valid(1'b0, lat, p);
        chk("rst_done_pre", p, 32'h0D8C);
        rst = 1; tick(); rst = 0;
        chk_reset8("rst_done");
        tick();

        // Randomised operands against the reference, both widths
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 1500; i++) begin
                logic [15:0] a, b;
                bit as, bs;
                a  = (w == 1) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 255));
                b  = (w == 1) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 255));
                as = 1'($urandom_range(0, 1));
                bs = 1'($urandom_range(0, 1));
                run_op(w == 1, a, b, as, bs, lat, p);
                chk((w == 1) ? "rnd16" : "rnd8", p, {32'h0, ref_mul(a, b, as, bs, (w == 1) ? 16 : 8)});
                chk((w == 1) ? "rnd16_lat" : "rnd8_lat", lat, (w == 1) ? 9 : 5);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
